// File: rtl/image_half_pkg.sv
// Shared coordinate/address types and the linear output-address helper for the 2:1 downscaler.
package image_half_pkg;

  localparam int COORD_W = 11;
  localparam int ADDR_W  = 11;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  // Output address of the 2x2 block containing input pixel (x,y).
  function automatic addr_t out_addr(input coord_t x, input coord_t y, input int new_width);
    logic [31:0] lin;
    lin = (32'(y) >> 1) * 32'(new_width) + (32'(x) >> 1);
    return addr_t'(lin);
  endfunction

endpackage

// File: rtl/image_half_linebuf.sv
// One-row buffer of horizontal pair results: written on even rows, read combinationally on odd rows.
// Latency: write visible next cycle, read is asynchronous; no backpressure.
module image_half_linebuf #(
  parameter int DEPTH = 32,
  parameter int W     = 9,
  parameter int IDX_W = 5
) (
  input  logic             clk_in,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [W-1:0]     i_wr_dat,
  output logic [W-1:0]     o_rd_dat
);

  logic [W-1:0] r_mem [DEPTH];

  // Contents are don't-care after reset, so no reset term: maps onto distributed RAM.
  always_ff @(posedge clk_in) begin
    if (i_wr_en) r_mem[i_idx] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_idx];

endmodule

// File: rtl/image_half_ds.sv
// Streaming 2:1 downscaler, one output per 2x2 block; output 1 cycle after the odd/odd pixel, no backpressure.
// IMAGE_HALF_AVG_EN defined: rounded 2x2 average; undefined: top-left pixel of each block.
module image_half_ds
  import image_half_pkg::*;
#(
  parameter int BIT_DEPTH  = 8,
  parameter int NEW_WIDTH  = 32,
  parameter int NEW_HEIGHT = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [BIT_DEPTH-1:0] data_in,
  input  coord_t               data_x_in,
  input  coord_t               data_y_in,
  input  logic                 data_valid_in,
  output logic [BIT_DEPTH-1:0] data_out,
  output addr_t                data_addr_out,
  output logic                 data_valid_out,
  output logic                 error_out,
  output logic                 busy_out
);

  localparam coord_t X_LAST    = coord_t'(2*NEW_WIDTH - 1);
  localparam coord_t Y_LAST    = coord_t'(2*NEW_HEIGHT - 1);
  localparam addr_t  LAST_ADDR = addr_t'(NEW_WIDTH*NEW_HEIGHT - 1);
  localparam int     IDX_W     = (NEW_WIDTH > 1) ? $clog2(NEW_WIDTH) : 1;

`ifdef IMAGE_HALF_AVG_EN
  localparam int LB_W = BIT_DEPTH + 1;
`else
  localparam int LB_W = BIT_DEPTH;
`endif

  coord_t               r_exp_x, r_exp_y;
  logic [BIT_DEPTH-1:0] r_h;
  logic [BIT_DEPTH-1:0] r_dout;
  addr_t                r_addr;
  logic                 r_vld, r_err, r_busy;

  logic                 w_is_origin, w_in_range, w_in_order;
  logic                 w_accept, w_drop, w_emit, w_lb_we, w_last;
  coord_t               w_nxt_x, w_nxt_y;
  addr_t                w_oaddr;
  logic [IDX_W-1:0]     w_idx;
  logic [LB_W-1:0]      w_lb_wdat, w_lb_rdat;
  logic [BIT_DEPTH-1:0] w_px;

  // (0,0) always restarts a frame; anything else must be the next raster position.
  assign w_is_origin = (data_x_in == '0) && (data_y_in == '0);
  assign w_in_range  = (data_x_in <= X_LAST) && (data_y_in <= Y_LAST);
  assign w_in_order  = (data_x_in == r_exp_x) && (data_y_in == r_exp_y);
  assign w_accept    = data_valid_in && (w_is_origin || (w_in_range && w_in_order));
  assign w_drop      = data_valid_in && !w_accept;

  assign w_emit  = w_accept &&  data_x_in[0] && data_y_in[0];
  assign w_lb_we = w_accept &&  data_x_in[0] && !data_y_in[0];
  assign w_idx   = data_x_in[IDX_W:1];
  assign w_oaddr = out_addr(data_x_in, data_y_in, NEW_WIDTH);
  assign w_last  = (w_oaddr == LAST_ADDR);

  always_comb begin
    w_nxt_x = data_x_in + coord_t'(1);
    w_nxt_y = data_y_in;
    if (data_x_in == X_LAST) begin
      w_nxt_x = '0;
      w_nxt_y = (data_y_in == Y_LAST) ? '0 : data_y_in + coord_t'(1);
    end
  end

`ifdef IMAGE_HALF_AVG_EN
  logic [BIT_DEPTH:0]   w_pair;
  logic [BIT_DEPTH+1:0] w_sum;

  assign w_pair    = {1'b0, r_h} + {1'b0, data_in};
  assign w_lb_wdat = w_pair;
  // Four-pixel sum plus 2 for round-half-up; fits in BIT_DEPTH+2 bits.
  assign w_sum     = {1'b0, w_lb_rdat} + {1'b0, w_pair} + (BIT_DEPTH+2)'(2);
  assign w_px      = BIT_DEPTH'(w_sum >> 2);
`else
  // At an even row's odd column r_h holds the block's top-left pixel.
  assign w_lb_wdat = r_h;
  assign w_px      = w_lb_rdat;
`endif

  image_half_linebuf #(
    .DEPTH (NEW_WIDTH),
    .W     (LB_W),
    .IDX_W (IDX_W)
  ) u_linebuf (
    .clk_in   (clk_in),
    .i_wr_en  (w_lb_we),
    .i_idx    (w_idx),
    .i_wr_dat (w_lb_wdat),
    .o_rd_dat (w_lb_rdat)
  );

  always_ff @(posedge clk_in) begin
    if (w_accept && !data_x_in[0]) r_h <= data_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_exp_x <= '0;
      r_exp_y <= '0;
      r_dout  <= '0;
      r_addr  <= '0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (w_drop) r_err <= 1'b1;
      if (w_accept) begin
        r_exp_x <= w_nxt_x;
        r_exp_y <= w_nxt_y;
        if (w_is_origin) r_busy <= 1'b1;
        if (w_emit) begin
          r_dout <= w_px;
          r_addr <= w_oaddr;
          r_vld  <= 1'b1;
          if (w_last) r_busy <= 1'b0;
        end
      end
    end
  end

  assign data_out       = r_dout;
  assign data_addr_out  = r_addr;
  assign data_valid_out = r_vld;
  assign error_out      = r_err;
  assign busy_out       = r_busy;

endmodule

// File: tb/tb_image_half_ds.sv
// Scoreboard bench for image_half_ds at NEW_WIDTH=NEW_HEIGHT=2 (4x4 input frames).
module tb_image_half_ds;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  data_in;
  logic [10:0] data_x_in, data_y_in;
  logic        data_valid_in;
  logic [7:0]  data_out;
  logic [10:0] data_addr_out;
  logic        data_valid_out, error_out, busy_out;

  typedef struct {
    int addr;
    int dat;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   ramp_tab[4];

  image_half_ds #(.BIT_DEPTH(8), .NEW_WIDTH(2), .NEW_HEIGHT(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .data_x_in      (data_x_in),
    .data_y_in      (data_y_in),
    .data_valid_in  (data_valid_in),
    .data_out       (data_out),
    .data_addr_out  (data_addr_out),
    .data_valid_out (data_valid_out),
    .error_out      (error_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per output strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (data_valid_out) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got addr=%0d data=%0d, expected no output", data_addr_out, data_out);
        end else begin
          e = q.pop_front();
          chk("out_addr", int'(data_addr_out), e.addr);
          chk("out_data", int'(data_out), e.dat);
          chk("out_latency_cyc", cyc, e.cyc);
          chk("busy_at_out", int'(busy_out), (e.addr == 3) ? 0 : 1);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      data_valid_in = 1'b0;
    end
  endtask

  task automatic send_px(input int x, input int y, input int d, input bit push, input int expd, input int gap);
    exp_t e;
    @(negedge clk_in);
    data_valid_in = 1'b1;
    data_x_in     = 11'(x);
    data_y_in     = 11'(y);
    data_in       = 8'(d);
    if (push && (x % 2 == 1) && (y % 2 == 1)) begin
      e.addr = (y / 2) * 2 + x / 2;
      e.dat  = expd;
      e.cyc  = cyc + 1;
      q.push_back(e);
    end
    idle(gap);
  endtask

  // mode 0: ramp 4*y+x, mode 1: all 255, mode 2: all 0.
  task automatic send_frame(input int mode, input int maxgap, input int npix);
    int d, e, gap, k;
    k = 0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        if (k < npix) begin
          d   = (mode == 0) ? 4 * y + x : ((mode == 1) ? 255 : 0);
          e   = (mode == 0) ? ramp_tab[(y / 2) * 2 + x / 2] : d;
          gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
          send_px(x, y, d, 1'b1, e, gap);
        end
        k++;
      end
    end
  endtask

  task automatic drain;
    int t;
    t = 0;
    idle(1);
    while (q.size() != 0 && t < 50) begin
      @(negedge clk_in);
      t++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_vld"},  int'(data_valid_out), 0);
    chk({tag, "_data"}, int'(data_out), 0);
    chk({tag, "_addr"}, int'(data_addr_out), 0);
    chk({tag, "_err"},  int'(error_out), 0);
    chk({tag, "_busy"}, int'(busy_out), 0);
  endtask

  initial begin
`ifdef IMAGE_HALF_AVG_EN
    ramp_tab = '{3, 5, 11, 13};
`else
    ramp_tab = '{0, 2, 8, 10};
`endif
    rst_in        = 1'b0;
    data_valid_in = 1'b0;
    data_in       = '0;
    data_x_in     = '0;
    data_y_in     = '0;
    repeat (3) @(negedge clk_in);
    #1;
    chk_reset_outs("reset");
    @(negedge clk_in);
    rst_in = 1'b1;

    // Ramp frame, back-to-back.
    send_frame(0, 0, 16);
    drain();
    chk("ramp_err", int'(error_out), 0);
    chk("ramp_busy_end", int'(busy_out), 0);

    // Saturated and zero frames.
    send_frame(1, 0, 16);
    send_frame(2, 0, 16);
    drain();
    chk("const_err", int'(error_out), 0);

    // Ramp frame with random idle gaps.
    send_frame(0, 5, 16);
    drain();
    chk("gaps_err", int'(error_out), 0);

    // Skip (1,0): (2,0) and (3,0) are dropped, then restart at (0,0).
    send_px(0, 0, 0, 1'b0, 0, 0);
    send_px(2, 0, 2, 1'b0, 0, 0);
    send_px(3, 0, 3, 1'b0, 0, 0);
    idle(1);
    chk("skip_err_set", int'(error_out), 1);
    chk("skip_busy", int'(busy_out), 1);
    send_frame(0, 0, 16);
    drain();
    chk("skip_err_sticky", int'(error_out), 1);
    chk("skip_busy_end", int'(busy_out), 0);

    // Reset after 6 pixels (block 0 already emitted), then a full frame.
    send_frame(0, 0, 6);
    @(negedge clk_in);
    data_valid_in = 1'b0;
    rst_in        = 1'b0;
    #1;
    chk_reset_outs("midreset");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    chk("midreset_queue", q.size(), 0);
    send_frame(0, 0, 16);
    drain();
    chk("post_reset_err", int'(error_out), 0);
    chk("post_reset_busy", int'(busy_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run exceeded 100000 time units, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
